// File: rtl/mem_access_ctrl_pkg.sv
// lc3b_types: shared definitions for the memory access controller.
//   mac_state_e : controller FSM states (IDLE, READ, WRITE, FINISH)
//   mac_err_e   : sticky status codes reported on mem_access_ctrl.err
//   lane_enable : byte-lane enable pattern for a 16-bit, two-lane memory
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } mac_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNALIGNED = 2'b01,
    ERR_TIMEOUT   = 2'b10
  } mac_err_e;

  // Word ops use both lanes; byte ops pick the lane named by the address LSB.
  function automatic logic [1:0] lane_enable(input logic byte_op, input logic addr_lsb);
    if (!byte_op) begin
      return 2'b11;
    end
    return addr_lsb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_format.sv
// mem_lane_format: combinational byte-lane steering for stores and
// lane selection plus sign extension for loads.
//   byte_op_i     : 1 = byte access, 0 = word access
//   addr_lsb_i    : byte address bit 0 (selects lane for byte ops)
//   wdata_i       : store data as captured from the control unit
//   mem_rdata_i   : raw memory read data
//   byte_enable_o : lane enables for the memory
//   lane_wdata_o  : store data steered onto the memory lanes
//   load_data_o   : formatted load result
import lc3b_types::*;

module mem_lane_format #(
  parameter int unsigned width = 16
) (
  input  logic             byte_op_i,
  input  logic             addr_lsb_i,
  input  logic [width-1:0] wdata_i,
  input  logic [width-1:0] mem_rdata_i,
  output logic [1:0]       byte_enable_o,
  output logic [width-1:0] lane_wdata_o,
  output logic [width-1:0] load_data_o
);

  logic [7:0] sel_byte;

  always_comb begin
    byte_enable_o = lane_enable(byte_op_i, addr_lsb_i);
    sel_byte      = addr_lsb_i ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
    if (byte_op_i) begin
      // Byte stores drive the low byte onto every lane; the enables pick the target.
      lane_wdata_o = {(width/8){wdata_i[7:0]}};
      load_data_o  = {{(width-8){sel_byte[7]}}, sel_byte};
    end else begin
      lane_wdata_o = wdata_i;
      load_data_o  = mem_rdata_i;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store between the control unit and
// a 16-bit byte-addressed memory with a bounded wait for mem_resp.
//   clk, reset            : clock, asynchronous active-high reset
//   start, we, byte_op    : request strobe and its type (captured in IDLE)
//   addr, wdata           : byte address and store data (captured in IDLE)
//   mem_read, mem_write   : memory strobes, held until mem_resp or timeout
//   mem_address           : word-aligned address to memory
//   mem_byte_enable       : lane enables
//   mem_wdata             : lane-steered store data
//   mem_resp, mem_rdata   : memory completion and read data
//   rdata, load_mdr       : formatted load result and MDR load strobe
//   done, err             : completion pulse and sticky status
import lc3b_types::*;

module mem_access_ctrl #(
  parameter int unsigned width   = 16,
  parameter int unsigned timeout = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             we,
  input  logic             byte_op,
  input  logic [width-1:0] addr,
  input  logic [width-1:0] wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [width-1:0] mem_address,
  output logic [1:0]       mem_byte_enable,
  output logic [width-1:0] mem_wdata,
  input  logic             mem_resp,
  input  logic [width-1:0] mem_rdata,
  output logic [width-1:0] rdata,
  output logic             load_mdr,
  output logic             done,
  output logic [1:0]       err
);

  localparam int unsigned CW = $clog2(timeout + 1);

  mac_state_e       state_q, state_d;
  mac_err_e         err_q, err_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             we_q, we_d;
  logic             byte_op_q, byte_op_d;
  logic [width-1:0] addr_q, addr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic [width-1:0] rdata_q, rdata_d;

  logic [1:0]       fmt_be;
  logic [width-1:0] fmt_wdata;
  logic [width-1:0] fmt_rdata;

  mem_lane_format #(
    .width(width)
  ) u_lane_format (
    .byte_op_i    (byte_op_q),
    .addr_lsb_i   (addr_q[0]),
    .wdata_i      (wdata_q),
    .mem_rdata_i  (mem_rdata),
    .byte_enable_o(fmt_be),
    .lane_wdata_o (fmt_wdata),
    .load_data_o  (fmt_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      wait_q    <= '0;
      we_q      <= 1'b0;
      byte_op_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      byte_op_q <= byte_op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wait_d    = wait_q;
    we_d      = we_q;
    byte_op_d = byte_op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          we_d      = we;
          byte_op_d = byte_op;
          addr_d    = addr;
          wdata_d   = wdata;
          wait_d    = '0;
          if (!byte_op && addr[0]) begin
            err_d   = ERR_UNALIGNED;
            state_d = FINISH;
          end else begin
            err_d   = ERR_NONE;
            state_d = we ? WRITE : READ;
          end
        end
      end
      READ, WRITE: begin
        // wait_q counts completed strobe cycles, so wait_q == timeout-1 marks the
        // timeout-th cycle; a response in that same cycle still wins.
        if (mem_resp) begin
          state_d = FINISH;
          if (state_q == READ) begin
            rdata_d = fmt_rdata;
          end
        end else if (wait_q == CW'(timeout - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = FINISH;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; memory-side buses stay at zero outside an active access.
  always_comb begin
    mem_read        = (state_q == READ);
    mem_write       = (state_q == WRITE);
    mem_address     = '0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    if (state_q == READ || state_q == WRITE) begin
      mem_address     = {addr_q[width-1:1], 1'b0};
      mem_byte_enable = fmt_be;
    end
    if (state_q == WRITE) begin
      mem_wdata = fmt_wdata;
    end
    done     = (state_q == FINISH);
    load_mdr = (state_q == FINISH) && !we_q && (err_q == ERR_NONE);
    rdata    = rdata_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        we;
  logic        byte_op;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] rdata;
  logic        load_mdr;
  logic        done;
  logic [1:0]  err;

  mem_access_ctrl #(
    .width  (16),
    .timeout(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .we             (we),
    .byte_op        (byte_op),
    .addr           (addr),
    .wdata          (wdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_byte_enable(mem_byte_enable),
    .mem_wdata      (mem_wdata),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .rdata          (rdata),
    .load_mdr       (load_mdr),
    .done           (done),
    .err            (err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          len;   // expected strobe cycles; -1 = not checked
  } req_t;

  typedef struct {
    logic [1:0]  err;
    logic        ld;
    logic [15:0] rdata;
    int          done_cyc;
  } cmp_t;

  typedef struct {
    logic        we;
    logic        bop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;
    int          lat;      // memory response N cycles after strobe rise; 0 = never
    logic        mem;      // access expected to reach memory
    logic [15:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
    logic [1:0]  e_err;
    logic        e_ld;
    int          e_done;   // start-to-done cycles
    int          e_len;
    logic        hold;     // keep start high an extra busy cycle
  } vec_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          mem_lat = 0;
  logic [15:0] mem_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp  = n_cmp + 1;
    n_fail = n_fail + 1;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Memory model: answers after mem_lat strobe cycles; bus carries junk otherwise.
  initial begin
    int cnt;
    cnt       = 0;
    mem_resp  = 1'b0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (mem_lat != 0 && cnt == mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_val;
        end else begin
          mem_resp  = 1'b0;
          mem_rdata = 16'hDEAD;
        end
        cnt = cnt + 1;
      end else begin
        cnt       = 0;
        mem_resp  = 1'b0;
        mem_rdata = 16'hDEAD;
      end
    end
  end

  // Monitor: pops expected memory requests on strobe rise, completions on done.
  initial begin
    logic prev;
    int   slen;
    int   cur_len;
    req_t r;
    cmp_t c;
    prev    = 1'b0;
    slen    = 0;
    cur_len = -1;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev) begin
        slen = 1;
        if (req_q.size() == 0) begin
          fail_evt("unexpected_strobe");
          cur_len = -1;
        end else begin
          r = req_q.pop_front();
          cur_len = r.len;
          chk("mem_read", {31'b0, mem_read}, {31'b0, r.rd});
          chk("mem_write", {31'b0, mem_write}, {31'b0, r.wr});
          chk("mem_address", {16'b0, mem_address}, {16'b0, r.addr});
          chk("mem_byte_enable", {30'b0, mem_byte_enable}, {30'b0, r.be});
          chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, r.wdata});
        end
      end else if (mem_read || mem_write) begin
        slen = slen + 1;
      end else if (prev && cur_len >= 0) begin
        chk("strobe_len", slen, cur_len);
      end
      prev = mem_read || mem_write;
      if (done) begin
        if (cmp_q.size() == 0) begin
          fail_evt("unexpected_done");
        end else begin
          c = cmp_q.pop_front();
          chk("err", {30'b0, err}, {30'b0, c.err});
          chk("load_mdr", {31'b0, load_mdr}, {31'b0, c.ld});
          chk("rdata", {16'b0, rdata}, {16'b0, c.rdata});
          chk("done_cycle", cyc, c.done_cyc);
        end
      end
    end
  end

  task automatic run_op(input vec_t v);
    req_t r;
    cmp_t c;
    @(negedge clk);
    mem_lat = v.lat;
    mem_val = v.mrdata;
    if (v.mem) begin
      r.rd = !v.we; r.wr = v.we; r.addr = v.e_addr; r.be = v.e_be;
      r.wdata = v.e_wdata; r.len = v.e_len;
      req_q.push_back(r);
    end
    c.err = v.e_err; c.ld = v.e_ld; c.rdata = v.e_rdata; c.done_cyc = cyc + v.e_done;
    cmp_q.push_back(c);
    start = 1'b1; we = v.we; byte_op = v.bop; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    if (v.hold) begin
      addr = 16'h0101;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (cmp_q.size() != 0) begin
      fail_evt("done_wait_bound");
      cmp_q.delete();
      req_q.delete();
    end
  endtask

  vec_t vt[11];

  initial begin
    //       we    bop   addr      wdata     mrdata   lat mem   e_addr    e_be   e_wdata   e_rdata   e_err  e_ld  done len hold
    vt[0]  = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 3, 1'b1, 16'h3000, 2'b11, 16'h0000, 16'hBEEF, 2'b00, 1'b1, 5, 4, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 16'h3001, 16'h0000, 16'h80FF, 1, 1'b1, 16'h3000, 2'b10, 16'h0000, 16'hFF80, 2'b00, 1'b1, 3, 2, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 16'h4000, 16'h12AB, 16'h0000, 2, 1'b1, 16'h4000, 2'b01, 16'hABAB, 16'hFF80, 2'b00, 1'b0, 4, 3, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 16'h3003, 16'h0000, 16'h1111, 1, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'hFF80, 2'b01, 1'b0, 1, 0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'h7F12, 4, 1'b1, 16'h2000, 2'b01, 16'h0000, 16'h0012, 2'b00, 1'b1, 6, 5, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 16'h5002, 16'hCAFE, 16'h0000, 1, 1'b1, 16'h5002, 2'b11, 16'hCAFE, 16'h0012, 2'b00, 1'b0, 3, 2, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 16'h2001, 16'h0000, 16'h7F12, 2, 1'b1, 16'h2000, 2'b10, 16'h0000, 16'h007F, 2'b00, 1'b1, 4, 3, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 16'h6000, 16'h0000, 16'h9999, 0, 1'b1, 16'h6000, 2'b11, 16'h0000, 16'h007F, 2'b10, 1'b0, 65, 64, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 16'h6002, 16'h0000, 16'h1234, 63, 1'b1, 16'h6002, 2'b11, 16'h0000, 16'h1234, 2'b00, 1'b1, 65, 64, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 16'h4001, 16'h00C3, 16'h0000, 1, 1'b1, 16'h4000, 2'b10, 16'hC3C3, 16'h1234, 2'b00, 1'b0, 3, 2, 1'b0};
    vt[10] = '{1'b0, 1'b0, 16'h7002, 16'h0000, 16'h5A5A, 2, 1'b1, 16'h7002, 2'b11, 16'h0000, 16'h5A5A, 2'b00, 1'b1, 4, 3, 1'b0};

    reset = 1'b1; start = 1'b0; we = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
    chk("rst_done_ld", {30'b0, done, load_mdr}, 32'h0);
    chk("rst_err", {30'b0, err}, 32'h0);
    chk("rst_rdata", {16'b0, rdata}, 32'h0);
    chk("rst_mem_bus", {mem_address, mem_wdata}, 32'h0);
    chk("rst_be", {30'b0, mem_byte_enable}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i]);
      @(negedge clk);
    end

    // Reset mid-READ: memory never answers, access must vanish without done.
    @(negedge clk);
    mem_lat = 0;
    begin
      req_t r;
      r.rd = 1'b1; r.wr = 1'b0; r.addr = 16'h7000; r.be = 2'b11; r.wdata = 16'h0000; r.len = -1;
      req_q.push_back(r);
    end
    start = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h7000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
    chk("arst_done_ld", {30'b0, done, load_mdr}, 32'h0);
    chk("arst_err", {30'b0, err}, 32'h0);
    chk("arst_rdata", {16'b0, rdata}, 32'h0);
    chk("arst_mem_bus", {mem_address, mem_wdata}, 32'h0);
    chk("arst_be", {30'b0, mem_byte_enable}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_op(vt[10]);
    repeat (4) @(negedge clk);
    chk("req_queue_drained", req_q.size(), 0);
    chk("cmp_queue_drained", cmp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
